exec_stage: RTL and testbench

- Execute stage directly downstream of the register file.
- Consumes the two register-file read operands, applies the decoded ALU operation, and drives the register file's write port (wr_en, dst id, dst data) with the registered result.
- Contains a same-cycle bypass for back-to-back dependent operations and an iterative multi-cycle unsigned multiplier.

---
 rtl/exec_stage_if.sv | 21 ++
 rtl/exec_stage.sv | 84 ++++++++
 tb/tb_exec_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/exec_stage_if.sv
// exec_stage_if: issue-side handshake/operands plus register-file write port and status for exec_stage.
interface exec_stage_if #(parameter int D = 8, parameter int I = 4);
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [I-1:0] dst_id;
   logic [I-1:0] src1_id;
   logic [I-1:0] src2_id;
   logic [D-1:0] src1_val;
   logic [D-1:0] src2_val;
   logic         wr_en;
   logic [I-1:0] wr_id;
   logic [D-1:0] wr_data;
   logic         flag_z;
   logic         flag_c;
   logic         busy;
   modport master (output in_valid, op, dst_id, src1_id, src2_id, src1_val, src2_val,
                   input in_ready, wr_en, wr_id, wr_data, flag_z, flag_c, busy);
   modport slave  (input in_valid, op, dst_id, src1_id, src2_id, src1_val, src2_val,
                   output in_ready, wr_en, wr_id, wr_data, flag_z, flag_c, busy);
endinterface

// File: rtl/exec_stage.sv
// exec_stage: ALU execute stage with write-port bypass and an iterative shift-add multiplier.
module exec_stage #(parameter int D = 8, parameter int I = 4) (
   input logic        clk,
   input logic        rst_n,
   exec_stage_if.slave bus
);
   localparam int CW = $clog2(D);
   localparam logic [0:0] IDLE = 1'b0, MUL = 1'b1;
   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic [D-1:0]  acc, acc_next, mcand, mplier, op1, op2;
   logic [I-1:0]  mdst;
   logic [D:0]    res;
   logic          accept, is_alu, is_mul, last;
   assign bus.in_ready = state == IDLE;
   assign bus.busy     = state == MUL;
   assign accept = bus.in_valid && bus.in_ready;
   assign is_alu = bus.op < 4'd7;
   assign is_mul = bus.op == 4'd7;
   assign last   = cnt == CW'(D - 1);
   // The register file commits wr_data on the same edge we sample, so forward it
   assign op1 = (bus.src1_id != '0 && bus.wr_en && bus.wr_id == bus.src1_id) ? bus.wr_data : bus.src1_val;
   assign op2 = (bus.src2_id != '0 && bus.wr_en && bus.wr_id == bus.src2_id) ? bus.wr_data : bus.src2_val;
   assign acc_next = acc + (mplier[cnt] ? mcand << cnt : '0);
   always_comb begin
      res = '0;
      case (bus.op)
         4'd0: res = {1'b0, op1} + {1'b0, op2};
         4'd1: res = {1'b0, op1} - {1'b0, op2};
         4'd2: res = {1'b0, op1 & op2};
         4'd3: res = {1'b0, op1 | op2};
         4'd4: res = {1'b0, op1 ^ op2};
         4'd5: res = {op1, 1'b0};
         4'd6: res = {op1[0], 1'b0, op1[D-1:1]};
         default: res = '0;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         mdst        <= '0;
         bus.wr_en   <= 1'b0;
         bus.wr_id   <= '0;
         bus.wr_data <= '0;
         bus.flag_z  <= 1'b0;
         bus.flag_c  <= 1'b0;
      end else if (state == MUL) begin
         acc       <= acc_next;
         cnt       <= cnt + 1'b1;
         bus.wr_en <= last && mdst != '0;
         if (last) begin
            state      <= IDLE;
            bus.flag_z <= acc_next == '0;
            bus.flag_c <= 1'b0;
            if (mdst != '0) begin
               bus.wr_id   <= mdst;
               bus.wr_data <= acc_next;
            end
         end
      end else begin
         bus.wr_en <= accept && is_alu && bus.dst_id != '0;
         if (accept && is_mul) begin
            state  <= MUL;
            mcand  <= op1;
            mplier <= op2;
            mdst   <= bus.dst_id;
            acc    <= '0;
            cnt    <= '0;
         end
         if (accept && is_alu) begin
            bus.flag_z <= res[D-1:0] == '0;
            bus.flag_c <= res[D];
            if (bus.dst_id != '0) begin
               bus.wr_id   <= bus.dst_id;
               bus.wr_data <= res[D-1:0];
            end
         end
      end
   end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed vector table plus multiply/reset sequences for exec_stage.
module tb_exec_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   always #5 clk = ~clk;
   exec_stage_if #(.D(8), .I(4)) bus();
   exec_stage #(.D(8), .I(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   typedef struct {
      logic [3:0] op;
      logic [3:0] dst, s1id, s2id;
      logic [7:0] s1v, s2v;
      logic       we;
      logic [7:0] data;
      logic       z, c;
   } vec_t;
   vec_t tbl[14];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] dst, input logic [3:0] s1id,
                        input logic [3:0] s2id, input logic [7:0] s1v, input logic [7:0] s2v);
      bus.in_valid = v;
      bus.op = op;
      bus.dst_id = dst;
      bus.src1_id = s1id;
      bus.src2_id = s2id;
      bus.src1_val = s1v;
      bus.src2_val = s2v;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // Accepts a MUL, holds a pending ADD 200+100 -> r6 during busy, then checks both results.
   task automatic mul_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp, input logic expz);
      int early;
      drive(1'b1, 4'd7, 4'd5, 4'd1, 4'd2, a, b);
      step();
      drive(1'b1, 4'd0, 4'd6, 4'd7, 4'd8, 8'd200, 8'd100);
      early = 0;
      for (int i = 0; i < 8; i++) begin
         if (!bus.busy || bus.in_ready || bus.wr_en) early++;
         step();
      end
      chk("mul_busy_window", early, 0);
      chk("mul_we", bus.wr_en, 1);
      chk("mul_id", bus.wr_id, 5);
      chk("mul_data", bus.wr_data, exp);
      chk("mul_z", bus.flag_z, expz);
      chk("mul_c", bus.flag_c, 0);
      chk("mul_ready", bus.in_ready, 1);
      step();
      drive(1'b0, 4'd9, 4'd0, 4'd0, 4'd0, 8'd0, 8'd0);
      chk("held_add_we", bus.wr_en, 1);
      chk("held_add_id", bus.wr_id, 6);
      chk("held_add_data", bus.wr_data, 44);
      chk("held_add_c", bus.flag_c, 1);
   endtask
   initial begin
      int stray;
      tbl[0]  = '{4'd0, 4'd3,  4'd1,  4'd2,  8'd200, 8'd100, 1'b1, 8'd44,  1'b0, 1'b1};
      tbl[1]  = '{4'd0, 4'd3,  4'd1,  4'd2,  8'd5,   8'd6,   1'b1, 8'd11,  1'b0, 1'b0};
      tbl[2]  = '{4'd1, 4'd4,  4'd3,  4'd5,  8'd0,   8'd11,  1'b1, 8'd0,   1'b1, 1'b0};
      tbl[3]  = '{4'd1, 4'd6,  4'd7,  4'd8,  8'd3,   8'd5,   1'b1, 8'hFE,  1'b0, 1'b1};
      tbl[4]  = '{4'd2, 4'd1,  4'd6,  4'd9,  8'd0,   8'h0F,  1'b1, 8'h0E,  1'b0, 1'b0};
      tbl[5]  = '{4'd3, 4'd2,  4'd10, 4'd11, 8'hA0,  8'h05,  1'b1, 8'hA5,  1'b0, 1'b0};
      tbl[6]  = '{4'd4, 4'd7,  4'd12, 4'd13, 8'hFF,  8'hFF,  1'b1, 8'h00,  1'b1, 1'b0};
      tbl[7]  = '{4'd0, 4'd0,  4'd14, 4'd15, 8'd7,   8'd9,   1'b0, 8'h00,  1'b0, 1'b0};
      tbl[8]  = '{4'd0, 4'd8,  4'd0,  4'd1,  8'd1,   8'd2,   1'b1, 8'd3,   1'b0, 1'b0};
      tbl[9]  = '{4'd6, 4'd2,  4'd3,  4'd4,  8'h81,  8'd0,   1'b1, 8'h40,  1'b0, 1'b1};
      tbl[10] = '{4'd9, 4'd2,  4'd0,  4'd0,  8'd0,   8'd0,   1'b0, 8'h00,  1'b0, 1'b1};
      tbl[11] = '{4'd5, 4'd2,  4'd5,  4'd6,  8'h80,  8'd0,   1'b1, 8'h00,  1'b1, 1'b1};
      tbl[12] = '{4'd0, 4'd9,  4'd7,  4'd8,  8'd255, 8'd1,   1'b1, 8'h00,  1'b1, 1'b1};
      tbl[13] = '{4'd1, 4'd10, 4'd1,  4'd9,  8'd20,  8'd99,  1'b1, 8'd20,  1'b0, 1'b0};
      drive(1'b0, 4'd9, 4'd0, 4'd0, 4'd0, 8'd0, 8'd0);
      #12;
      chk("rst_we", bus.wr_en, 0);
      chk("rst_id", bus.wr_id, 0);
      chk("rst_data", bus.wr_data, 0);
      chk("rst_flags", {bus.flag_z, bus.flag_c}, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ready", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, tbl[i].op, tbl[i].dst, tbl[i].s1id, tbl[i].s2id, tbl[i].s1v, tbl[i].s2v);
         step();
         chk($sformatf("v%0d_we", i), bus.wr_en, tbl[i].we);
         if (tbl[i].we) begin
            chk($sformatf("v%0d_id", i), bus.wr_id, tbl[i].dst);
            chk($sformatf("v%0d_data", i), bus.wr_data, tbl[i].data);
         end
         chk($sformatf("v%0d_z", i), bus.flag_z, tbl[i].z);
         chk($sformatf("v%0d_c", i), bus.flag_c, tbl[i].c);
         chk($sformatf("v%0d_ready", i), bus.in_ready, 1);
      end
      drive(1'b0, 4'd9, 4'd0, 4'd0, 4'd0, 8'd0, 8'd0);
      step();
      chk("pulse_end", bus.wr_en, 0);
      mul_seq(8'd13, 8'd11, 8'd143, 1'b0);
      mul_seq(8'd16, 8'd16, 8'd0, 1'b1);
      // Abort a multiply with reset at iteration 4
      drive(1'b1, 4'd7, 4'd5, 4'd1, 4'd2, 8'd13, 8'd11);
      step();
      drive(1'b0, 4'd9, 4'd0, 4'd0, 4'd0, 8'd0, 8'd0);
      for (int i = 0; i < 4; i++) step();
      chk("pre_abort_busy", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_we", bus.wr_en, 0);
      chk("abort_data", bus.wr_data, 0);
      chk("abort_flags", {bus.flag_z, bus.flag_c}, 0);
      chk("abort_busy", bus.busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.wr_en) stray++;
      end
      chk("abort_no_write", stray, 0);
      chk("abort_ready", bus.in_ready, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
